alu_arbiter: RTL

Sequencer and two-port arbiter in front of the shared `ALU_unit`. It accepts operation requests from two clients (port 0 and port 1) and arbitrates round-robin. It drives the ALU's edge-triggered `ena` with a clean low-high-low pulse, waits extra cycles for multiply functions, and registers the results and flags. It returns them to the winning client with a one-cycle `done` strobe.

---
 rtl/alu_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Two-client round-robin arbiter and sequencer in front of a shared ALU whose
// inputs are captured on the rising edge of `alu_ena`. The winning client's
// operands are latched at its grant. The ALU sees a clean low-high-low enable
// pulse with settled inputs. Multiply functions get extra settling cycles.
// Results and flags are registered and returned with a one-cycle done strobe.
//
// Optional feature (compile-time macro ALU_ARB_ILLEGAL_CHK_EN):
//   When defined, a function code above 11 is never sent to the ALU. The op
//   completes early with err_o, and the results and flags are cleared.
//   When undefined, err_o is tied low and every code is forwarded.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   req0/1                   client request levels
//   func0/1, a0/1, b0/1, sh0/1  client operation fields
//   gnt0/1                   one-cycle grant, operands latched at this edge
//   done0/1                  one-cycle completion strobe
//   err_o                    illegal-function completion (macro build only)
//   res1_o, res2_o, flags_o  registered results, {carry, sign, ovf, zero}
//   busy_o                   FSM not in IDLE
//   alu_inp1/2, alu_shAmt, alu_func, alu_ena   drive the ALU
//   alu_res1/2, alu_carry/sign/ovf/zero        ALU outputs
//   fsm_state                current FSM state, for observation
//
// Client handshake:
//   A client holds req high until its done strobe. The request is accepted
//   only in IDLE, and acceptance is signalled by a one-cycle gnt. After gnt,
//   the operands are no longer needed. req must be low by the edge that ends
//   the done cycle, or it counts as a new request. A losing client simply
//   stays pending; nothing about it is latched.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [5:0]       func0,
    input  logic [5:0]       func1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic [4:0]       sh0,
    input  logic [4:0]       sh1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err_o,
    output logic [WIDTH-1:0] res1_o,
    output logic [WIDTH-1:0] res2_o,
    output logic [3:0]       flags_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] alu_inp1,
    output logic [WIDTH-1:0] alu_inp2,
    output logic [4:0]       alu_shAmt,
    output logic [5:0]       alu_func,
    output logic             alu_ena,
    input  logic [WIDTH-1:0] alu_res1,
    input  logic [WIDTH-1:0] alu_res2,
    input  logic             alu_carry,
    input  logic             alu_sign,
    input  logic             alu_ovf,
    input  logic             alu_zero,
    output logic [2:0]       fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_FIRE    = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Terminal count of the multiply wait counter. It is only used when
    // MUL_LAT > 0.
    localparam logic [3:0] LAT_LAST = (MUL_LAT > 0) ? 4'(MUL_LAT - 1) : 4'd0;
    localparam bit         HAS_LAT  = (MUL_LAT > 0);

    state_t     state;
    state_t     next_state;
    logic       last_served;   // port served most recently; resets to 1
    logic       winner;        // port owning the current operation
    logic [3:0] wait_cnt;
    logic       any_req;
    logic       pick1;
    logic       is_mul;

    assign any_req = req0 | req1;
    // A lone request wins outright. On a tie, the port not served last wins.
    assign pick1   = req1 & (~req0 | ~last_served);
    assign is_mul  = (alu_func == 6'd1) || (alu_func == 6'd2);

    assign busy_o    = (state != S_IDLE);
    assign fsm_state = state;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    logic illegal;
    logic err_flag;
    logic err_q;
    assign illegal = (alu_func > 6'd11);
    assign err_o   = err_q;
`else
    assign err_o   = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (any_req) next_state = S_SETUP;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            S_SETUP:   next_state = illegal ? S_DONE : S_FIRE;
`else
            S_SETUP:   next_state = S_FIRE;
`endif
            S_FIRE:    next_state = (is_mul && HAS_LAT) ? S_WAIT : S_CAPTURE;
            S_WAIT:    if (wait_cnt == LAT_LAST) next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // ---------------- registered outputs and datapath ----------------
    // All strobes are registered, so each output is one edge behind the
    // state that produces it. alu_ena is high for the cycle after FIRE, and
    // done is high for the cycle after DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            alu_ena     <= 1'b0;
            alu_inp1    <= '0;
            alu_inp2    <= '0;
            alu_shAmt   <= '0;
            alu_func    <= '0;
            res1_o      <= '0;
            res2_o      <= '0;
            flags_o     <= '0;
            last_served <= 1'b1;
            winner      <= 1'b0;
            wait_cnt    <= '0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            err_flag    <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            alu_ena <= (state == S_FIRE);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            err_q   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        winner <= pick1;
                        gnt0   <= ~pick1;
                        gnt1   <= pick1;
                        if (pick1) begin
                            alu_inp1  <= a1;
                            alu_inp2  <= b1;
                            alu_shAmt <= sh1;
                            alu_func  <= func1;
                        end else begin
                            alu_inp1  <= a0;
                            alu_inp2  <= b0;
                            alu_shAmt <= sh0;
                            alu_func  <= func0;
                        end
                    end
                end
                S_SETUP: begin
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                    err_flag <= illegal;
`endif
                end
                S_FIRE:  wait_cnt <= '0;
                S_WAIT:  wait_cnt <= wait_cnt + 4'd1;
                S_CAPTURE: begin
                    res1_o  <= alu_res1;
                    res2_o  <= alu_res2;
                    flags_o <= {alu_carry, alu_sign, alu_ovf, alu_zero};
                end
                S_DONE: begin
                    done0       <= ~winner;
                    done1       <= winner;
                    last_served <= winner;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                    if (err_flag) begin
                        err_q   <= 1'b1;
                        res1_o  <= '0;
                        res2_o  <= '0;
                        flags_o <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
